hours: RTL

//  Hour stage of the clock chain, directly downstream of the minutes counter.

---
 rtl/hours.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hours.sv
// -----------------------------------------------------------------------------
// hours -- hour stage of the clock chain, fed by the minutes counter.
//
// Keeps a 0..23 hour register that advances on changeHour pulses and on rising
// edges of a manual advance button. It can be loaded through a level-based
// set handshake. The hour is shown in 24h or 12h form, with BCD digits and a
// PM flag. changeDay pulses on a 23->0 wrap caused by changeHour.
//
// Parameters
//   RESET_HOUR  24h value loaded on reset (0..23)
// Ports
//   clkMSec    in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   changeHour in   one-cycle advance pulse from the minutes stage
//   mode24     in   1 = 24h display, 0 = 12h display
//   incBtn     in   manual advance button level (already debounced)
//   setReq     in   set request level, held until answered
//   setHour    in   requested 24h hour, sampled when the request is accepted
//   setAck     out  one-cycle pulse: setHour loaded
//   setErr     out  one-cycle pulse: setHour out of range, nothing loaded
//   hour       out  displayed hour (0..23 or 1..12)
//   hourTens   out  BCD tens digit of the displayed hour
//   hourOnes   out  BCD ones digit of the displayed hour
//   pm         out  internal hour >= 12
//   changeDay  out  one-cycle pulse on the changeHour-driven 23->0 wrap
// -----------------------------------------------------------------------------
module hours #(
  parameter int RESET_HOUR = 0
) (
  input  logic       clkMSec,
  input  logic       reset,
  input  logic       changeHour,
  input  logic       mode24,
  input  logic       incBtn,
  input  logic       setReq,
  input  logic [4:0] setHour,
  output logic       setAck,
  output logic       setErr,
  output logic [4:0] hour,
  output logic [1:0] hourTens,
  output logic [3:0] hourOnes,
  output logic       pm,
  output logic       changeDay
);

  typedef enum logic [1:0] {IDLE, ACK, ERR, WAIT_REL} setState_t;

  setState_t  setState;
  logic [4:0] hour24;
  logic       incBtnQ;

  logic       btnRise;
  logic       setValid;
  logic       setLoad;
  logic [4:0] hourInc;

  assign btnRise  = incBtn & ~incBtnQ;
  assign setValid = (setHour < 5'd24);
  assign setLoad  = (setState == IDLE) && setReq && setValid;
  assign hourInc  = (hour24 == 5'd23) ? 5'd0 : hour24 + 5'd1;

  always_ff @(posedge clkMSec) begin
    if (reset) begin
      hour24    <= 5'(RESET_HOUR);
      setState  <= IDLE;
      setAck    <= 1'b0;
      setErr    <= 1'b0;
      changeDay <= 1'b0;
      // Treat the button as already pressed so a press held through reset
      // must be released before it can advance the hour.
      incBtnQ   <= 1'b1;
    end else begin
      incBtnQ   <= incBtn;
      setAck    <= 1'b0;
      setErr    <= 1'b0;
      changeDay <= 1'b0;

      // A load wins over counting; a changeHour/button in the same cycle is
      // dropped. Coincident changeHour and button edge advance by one only.
      if (setLoad) begin
        hour24 <= setHour;
      end else if (changeHour || btnRise) begin
        hour24    <= hourInc;
        changeDay <= changeHour && (hour24 == 5'd23);
      end

      case (setState)
        IDLE: begin
          if (setReq) begin
            if (setValid) begin
              setState <= ACK;
              setAck   <= 1'b1;
            end else begin
              setState <= ERR;
              setErr   <= 1'b1;
            end
          end
        end
        ACK, ERR: setState <= WAIT_REL;
        // One response per request: wait for the requester to drop setReq.
        WAIT_REL: if (!setReq) setState <= IDLE;
        default:  setState <= IDLE;
      endcase
    end
  end

  // Display decode.
  logic [4:0] hour12;
  logic [4:0] onesWide;

  always_comb begin
    if (hour24 == 5'd0) begin
      hour12 = 5'd12;
    end else if (hour24 > 5'd12) begin
      hour12 = hour24 - 5'd12;
    end else begin
      hour12 = hour24;
    end
  end

  assign hour = mode24 ? hour24 : hour12;
  assign pm   = (hour24 >= 5'd12);

  always_comb begin
    if (hour >= 5'd20) begin
      hourTens = 2'd2;
      onesWide = hour - 5'd20;
    end else if (hour >= 5'd10) begin
      hourTens = 2'd1;
      onesWide = hour - 5'd10;
    end else begin
      hourTens = 2'd0;
      onesWide = hour;
    end
  end

  assign hourOnes = onesWide[3:0];

endmodule
